// File: rtl/tx_pkg.sv
// Shared types and default sizing for the transmit pulse sequencer.
// Holds the sequencer state encoding and the default parameter values.
package tx_pkg;

    localparam int TX_NUM_CH     = 64;
    localparam int TX_DELAY_DW   = 22;
    localparam int TX_DELAY_FRAC = 4;
    localparam int TX_CNT_DW     = 12;
    localparam int TX_PULSE_DW   = 4;
    localparam int TX_POINTS_DW  = 13;

    typedef enum logic [1:0] {
        IDLE,
        WAIT_DELAY,
        FIRE,
        POINT_END
    } tx_state_e;

endpackage

// File: rtl/tx_channel_pulser.sv
// One transducer channel: captures its rounded delay and produces a delayed
// burst of P pulses of H-cycle half-period, registered onto tx_out.
module tx_channel_pulser
    import tx_pkg::*;
#(
    parameter int DELAY_DW   = TX_DELAY_DW,
    parameter int DELAY_FRAC = TX_DELAY_FRAC,
    parameter int CNT_DW     = TX_CNT_DW,
    parameter int PULSE_DW   = TX_PULSE_DW,
    parameter int TICK_DW    = TX_CNT_DW + 2 * TX_PULSE_DW + 1
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  load,
    input  logic                  fire,
    input  logic                  enable,
    input  logic [DELAY_DW-1:0]   delay_word,
    input  logic [TICK_DW-1:0]    tick,
    input  logic [PULSE_DW-1:0]   half,
    input  logic [PULSE_DW:0]     period_m1,
    input  logic [2*PULSE_DW:0]   pulse_len,
    output logic                  tx_out,
    output logic                  finished
);

    localparam int ROUND_ADD = (DELAY_FRAC > 0) ? (2 ** (DELAY_FRAC - 1)) : 0;
    localparam logic [DELAY_DW:0] CNT_MAX = (DELAY_DW + 1)'((2 ** CNT_DW) - 1);

    logic [DELAY_DW:0]    sum;
    logic [DELAY_DW:0]    rounded;
    logic [CNT_DW-1:0]    d_next;
    logic [CNT_DW-1:0]    d_r;
    logic [PULSE_DW:0]    ph;
    logic [TICK_DW-1:0]   start_tick;
    logic [TICK_DW-1:0]   end_tick;
    logic                 started;
    logic                 active;

    // Round half-up, then clamp to the tick range.
    always_comb begin
        sum     = {1'b0, delay_word} + (DELAY_DW + 1)'(ROUND_ADD);
        rounded = sum >> DELAY_FRAC;
        d_next  = (rounded > CNT_MAX) ? '1 : rounded[CNT_DW-1:0];
    end

    always_comb begin
        start_tick = TICK_DW'(d_r);
        end_tick   = TICK_DW'(d_r) + TICK_DW'(pulse_len);
        started    = (tick >= start_tick);
        active     = enable && started && (tick < end_tick) && (ph < {1'b0, half});
        finished   = !enable || (tick >= end_tick);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            d_r <= '0;
        end else if (load) begin
            d_r <= d_next;
        end
    end

    // ph tracks (tick - D) mod 2H once the channel's delay has elapsed.
    always_ff @(posedge clk) begin
        if (rst || load) begin
            ph <= '0;
        end else if (fire && started) begin
            ph <= (ph == period_m1) ? '0 : ph + (PULSE_DW + 1)'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            tx_out <= 1'b0;
        end else begin
            tx_out <= fire && active;
        end
    end

endmodule

// File: rtl/tx_pulse_sequencer.sv
// Scanline transmit sequencer: per point, accepts a delay vector and fires
// delayed pulse bursts on every enabled channel, then reports point/scanline end.
module tx_pulse_sequencer
    import tx_pkg::*;
#(
    parameter int NUM_CH     = TX_NUM_CH,
    parameter int DELAY_DW   = TX_DELAY_DW,
    parameter int DELAY_FRAC = TX_DELAY_FRAC,
    parameter int CNT_DW     = TX_CNT_DW,
    parameter int PULSE_DW   = TX_PULSE_DW,
    parameter int POINTS_DW  = TX_POINTS_DW
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic                         start,
    input  logic                         abort,
    input  logic [POINTS_DW-1:0]         num_points,
    input  logic [NUM_CH-1:0]            ch_mask,
    input  logic [PULSE_DW-1:0]          num_pulses,
    input  logic [PULSE_DW-1:0]          half_period,
    input  logic                         delay_valid,
    output logic                         delay_ready,
    input  logic [NUM_CH*DELAY_DW-1:0]   delay_data,
    output logic [NUM_CH-1:0]            tx_out,
    output logic                         point_done,
    output logic                         done,
    output logic                         busy
);

    localparam int TICK_DW = CNT_DW + 2 * PULSE_DW + 1;

    tx_state_e               state;
    tx_state_e               state_n;

    logic [POINTS_DW-1:0]    pts_r;
    logic [NUM_CH-1:0]       mask_r;
    logic [PULSE_DW-1:0]     hp_r;
    logic [2*PULSE_DW:0]     len_r;
    logic [POINTS_DW-1:0]    point_cnt;
    logic [TICK_DW-1:0]      tick;
    logic                    zero_done_r;

    logic [PULSE_DW-1:0]     hp_eff;
    logic [PULSE_DW-1:0]     np_eff;
    logic [2*PULSE_DW:0]     len_n;
    logic [PULSE_DW:0]       period_m1;
    logic                    accept_start;
    logic                    load;
    logic                    fire;
    logic                    last_point;
    logic [NUM_CH-1:0]       ch_finished;
    logic                    all_finished;

    always_comb begin
        hp_eff       = (half_period == '0) ? PULSE_DW'(1) : half_period;
        np_eff       = (num_pulses == '0) ? PULSE_DW'(1) : num_pulses;
        len_n        = ((2 * PULSE_DW + 1)'(hp_eff) * (2 * PULSE_DW + 1)'(np_eff)) << 1;
        period_m1    = {hp_r, 1'b0} - (PULSE_DW + 1)'(1);
        accept_start = (state == IDLE) && start && !abort;
        load         = (state == WAIT_DELAY) && delay_valid && !abort;
        fire         = (state == FIRE) && !abort;
        last_point   = ({1'b0, point_cnt} + (POINTS_DW + 1)'(1)) == {1'b0, pts_r};
        all_finished = &ch_finished;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_n;
        end
    end

    always_comb begin
        state_n = state;
        if (abort) begin
            state_n = IDLE;
        end else begin
            case (state)
                IDLE:       if (start && num_points != '0) state_n = WAIT_DELAY;
                WAIT_DELAY: if (delay_valid)               state_n = FIRE;
                FIRE:       if (all_finished)              state_n = POINT_END;
                POINT_END:  state_n = last_point ? IDLE : WAIT_DELAY;
                default:    state_n = IDLE;
            endcase
        end
    end

    always_comb begin
        delay_ready = (state == WAIT_DELAY);
        busy        = (state != IDLE);
        point_done  = (state == POINT_END);
        done        = ((state == POINT_END) && last_point) || zero_done_r;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            pts_r  <= '0;
            mask_r <= '0;
            hp_r   <= '0;
            len_r  <= '0;
        end else if (accept_start) begin
            pts_r  <= num_points;
            mask_r <= ch_mask;
            hp_r   <= hp_eff;
            len_r  <= len_n;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            zero_done_r <= 1'b0;
            point_cnt   <= '0;
            tick        <= '0;
        end else begin
            zero_done_r <= accept_start && (num_points == '0);
            if (state == IDLE) begin
                point_cnt <= '0;
            end else if (state == POINT_END) begin
                point_cnt <= point_cnt + POINTS_DW'(1);
            end
            tick <= (state == FIRE) ? tick + TICK_DW'(1) : '0;
        end
    end

    for (genvar n = 0; n < NUM_CH; n++) begin : g_ch
        tx_channel_pulser #(
            .DELAY_DW   (DELAY_DW),
            .DELAY_FRAC (DELAY_FRAC),
            .CNT_DW     (CNT_DW),
            .PULSE_DW   (PULSE_DW),
            .TICK_DW    (TICK_DW)
        ) u_pulser (
            .clk        (clk),
            .rst        (rst),
            .load       (load),
            .fire       (fire),
            .enable     (mask_r[n]),
            .delay_word (delay_data[n*DELAY_DW +: DELAY_DW]),
            .tick       (tick),
            .half       (hp_r),
            .period_m1  (period_m1),
            .pulse_len  (len_r),
            .tx_out     (tx_out[n]),
            .finished   (ch_finished[n])
        );
    end

endmodule

// File: tb/tb_tx_pulse_sequencer.sv
// Self-checking bench for tx_pulse_sequencer using an arithmetic pulse model.
module tb_tx_pulse_sequencer;

    localparam int NCH = 4;
    localparam int DW  = 22;
    localparam int PDW = 4;
    localparam int PTW = 13;

    logic              clk = 1'b0;
    logic              rst = 1'b1;
    logic              start = 1'b0;
    logic              abort = 1'b0;
    logic [PTW-1:0]    num_points = '0;
    logic [NCH-1:0]    ch_mask = '0;
    logic [PDW-1:0]    num_pulses = '0;
    logic [PDW-1:0]    half_period = '0;
    logic              delay_valid = 1'b0;
    logic              delay_ready;
    logic [NCH*DW-1:0] delay_data = '0;
    logic [NCH-1:0]    tx_out;
    logic              point_done;
    logic              done;
    logic              busy;

    int n_checks = 0;
    int n_pass   = 0;

    tx_pulse_sequencer #(
        .NUM_CH     (NCH),
        .DELAY_DW   (DW),
        .DELAY_FRAC (4),
        .CNT_DW     (12),
        .PULSE_DW   (PDW),
        .POINTS_DW  (PTW)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .start       (start),
        .abort       (abort),
        .num_points  (num_points),
        .ch_mask     (ch_mask),
        .num_pulses  (num_pulses),
        .half_period (half_period),
        .delay_valid (delay_valid),
        .delay_ready (delay_ready),
        .delay_data  (delay_data),
        .tx_out      (tx_out),
        .point_done  (point_done),
        .done        (done),
        .busy        (busy)
    );

    always #5 clk = ~clk;

    // Model: channel n high j cycles after the handshake when t=j-2-D is inside the burst.
    function automatic logic [NCH-1:0] exp_tx(input int j, input int d [NCH],
                                              input logic [NCH-1:0] m, input int he, input int pe);
        logic [NCH-1:0] r;
        int t;
        r = '0;
        for (int n = 0; n < NCH; n++) begin
            t = j - 2 - d[n];
            if (m[n] && t >= 0 && t < 2 * he * pe && (t % (2 * he)) < he) r[n] = 1'b1;
        end
        return r;
    endfunction

    task automatic start_scan(input int npts, input logic [NCH-1:0] m, input int np, input int hp);
        num_points  = PTW'(npts);
        ch_mask     = m;
        num_pulses  = PDW'(np);
        half_period = PDW'(hp);
        start       = 1'b1;
    endtask

    // Handshake one point and compare every following cycle with the model.
    task automatic fire_point(input logic [DW-1:0] w [NCH], input logic [NCH-1:0] m,
                              input int h, input int p, input bit last, input int start_at,
                              input int kill_at, input bit kill_rst, input string name);
        int he, pe, dmax, pd;
        int d [NCH];
        logic [NCH-1:0] etx;
        logic [3:0] est;
        he = (h == 0) ? 1 : h;
        pe = (p == 0) ? 1 : p;
        dmax = -1;
        for (int n = 0; n < NCH; n++) begin
            d[n] = (int'(w[n]) + 8) / 16;
            if (d[n] > 4095) d[n] = 4095;
            if (m[n] && d[n] > dmax) dmax = d[n];
        end
        pd = (dmax < 0) ? 2 : 2 + dmax + 2 * he * pe;

        @(negedge clk);
        start       = 1'b0;
        num_points  = PTW'($urandom);
        ch_mask     = NCH'($urandom);
        num_pulses  = PDW'($urandom);
        half_period = PDW'($urandom);
        n_checks++;
        if ({busy, delay_ready, tx_out} !== {2'b11, {NCH{1'b0}}})
            $display("FAIL %s handshake-cycle busy/ready/tx: got %b expected %b",
                     name, {busy, delay_ready, tx_out}, {2'b11, {NCH{1'b0}}});
        else n_pass++;
        delay_valid = 1'b1;
        for (int n = 0; n < NCH; n++) delay_data[n*DW +: DW] = w[n];

        for (int j = 1; j <= pd; j++) begin
            @(negedge clk);
            delay_valid = 1'b0;
            delay_data  = (NCH*DW)'({$urandom, $urandom, $urandom});
            start       = 1'b0;
            if (kill_at >= 0 && j == kill_at + 1) begin
                abort = 1'b0;
                rst   = 1'b0;
                for (int k = 0; k < 8; k++) begin
                    if (k > 0) @(negedge clk);
                    n_checks++;
                    if ({tx_out, point_done, done, busy, delay_ready} !== '0)
                        $display("FAIL %s after-kill c+%0d tx/pd/done/busy/ready: got %b expected 0",
                                 name, j + k, {tx_out, point_done, done, busy, delay_ready});
                    else n_pass++;
                end
                return;
            end
            etx = exp_tx(j, d, m, he, pe);
            est = {j == pd, last && j == pd, 1'b1, 1'b0};
            n_checks++;
            if (tx_out !== etx)
                $display("FAIL %s tx_out c+%0d: got %b expected %b", name, j, tx_out, etx);
            else n_pass++;
            n_checks++;
            if ({point_done, done, busy, delay_ready} !== est)
                $display("FAIL %s pd/done/busy/ready c+%0d: got %b expected %b",
                         name, j, {point_done, done, busy, delay_ready}, est);
            else n_pass++;
            if (j == start_at) begin
                start      = 1'b1;
                num_points = PTW'(5);
            end
            if (j == kill_at) begin
                if (kill_rst) rst = 1'b1;
                else          abort = 1'b1;
            end
        end
    endtask

    task automatic check_idle(input string name);
        @(negedge clk);
        n_checks++;
        if ({tx_out, point_done, done, busy, delay_ready} !== '0)
            $display("FAIL %s idle tx/pd/done/busy/ready: got %b expected 0",
                     name, {tx_out, point_done, done, busy, delay_ready});
        else n_pass++;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        repeat (3) @(negedge clk);
        n_checks++;
        if ({tx_out, delay_ready, point_done, done, busy} !== '0)
            $display("FAIL reset outputs: got %b expected 0", {tx_out, delay_ready, point_done, done, busy});
        else n_pass++;
        rst = 1'b0;
        check_idle("reset_release");
    endtask

    task automatic test_basic(input string name);
        logic [DW-1:0] w [NCH];
        w = '{22'h0, 22'h30, 22'h55, 22'h7};
        start_scan(1, 4'b0011, 2, 2);
        fire_point(w, 4'b0011, 2, 2, 1'b1, -1, -1, 1'b0, name);
        check_idle(name);
    endtask

    task automatic test_rounding();
        logic [DW-1:0] w [NCH];
        w = '{22'h38, 22'h37, 22'h3FFFFF, 22'h7};
        start_scan(1, 4'b1111, 0, 0);
        fire_point(w, 4'b1111, 0, 0, 1'b1, -1, -1, 1'b0, "rounding");
        check_idle("rounding");
    endtask

    task automatic run_scan(input int npts, input logic [NCH-1:0] m, input int h, input int p,
                            input int gap, input int wmax, input string name);
        logic [DW-1:0] w [NCH];
        start_scan(npts, m, p, h);
        for (int pt = 0; pt < npts; pt++) begin
            if (pt > 0) begin
                repeat (gap) begin
                    @(negedge clk);
                    delay_data = (NCH*DW)'({$urandom, $urandom, $urandom});
                    n_checks++;
                    if ({busy, delay_ready, point_done, done, tx_out} !== {4'b1100, {NCH{1'b0}}})
                        $display("FAIL %s gap busy/ready/pd/done/tx: got %b expected %b", name,
                                 {busy, delay_ready, point_done, done, tx_out}, {4'b1100, {NCH{1'b0}}});
                    else n_pass++;
                end
            end
            for (int n = 0; n < NCH; n++) w[n] = DW'($urandom_range(wmax, 0));
            fire_point(w, m, h, p, pt == npts - 1, -1, -1, 1'b0, name);
        end
        check_idle(name);
    endtask

    task automatic test_multi_point();
        logic [NCH-1:0] m;
        m = NCH'($urandom_range(15, 1));
        run_scan(3, m, $urandom_range(3, 0), $urandom_range(3, 0), 5, 255, "multi_point");
    endtask

    task automatic test_zero_cases();
        logic [DW-1:0] w [NCH];
        for (int n = 0; n < NCH; n++) w[n] = DW'($urandom_range(255, 0));
        start_scan(1, 4'b0000, 3, 3);
        fire_point(w, 4'b0000, 3, 3, 1'b1, -1, -1, 1'b0, "all_masked");
        check_idle("all_masked");
        start_scan(0, 4'b1111, 1, 1);
        @(negedge clk);
        start = 1'b0;
        n_checks++;
        if ({done, busy, delay_ready, point_done, tx_out} !== {4'b1000, {NCH{1'b0}}})
            $display("FAIL zero_points done/busy/ready/pd/tx: got %b expected %b",
                     {done, busy, delay_ready, point_done, tx_out}, {4'b1000, {NCH{1'b0}}});
        else n_pass++;
        check_idle("zero_points_after");
    endtask

    task automatic test_abort();
        logic [DW-1:0] w [NCH];
        w = '{22'h0, 22'h30, 22'h0, 22'h0};
        start_scan(1, 4'b0011, 2, 2);
        fire_point(w, 4'b0011, 2, 2, 1'b1, -1, 4, 1'b0, "abort");
        test_basic("after_abort");
    endtask

    task automatic test_start_in_fire();
        logic [DW-1:0] w [NCH];
        w = '{22'h0, 22'h30, 22'h0, 22'h0};
        start_scan(1, 4'b0011, 2, 2);
        fire_point(w, 4'b0011, 2, 2, 1'b1, 2, -1, 1'b0, "start_in_fire");
        check_idle("start_in_fire");
    endtask

    task automatic test_rst_mid_fire();
        logic [DW-1:0] w [NCH];
        w = '{22'h0, 22'h30, 22'h0, 22'h0};
        start_scan(2, 4'b0011, 2, 2);
        fire_point(w, 4'b0011, 2, 2, 1'b0, -1, 3, 1'b1, "rst_mid_fire");
    endtask

    task automatic test_random();
        for (int i = 0; i < 6; i++) begin
            run_scan($urandom_range(3, 1), NCH'($urandom), $urandom_range(4, 0),
                     $urandom_range(4, 0), $urandom_range(3, 0), 511, "random");
        end
    endtask

    initial begin
        test_reset();
        test_basic("basic");
        test_rounding();
        test_multi_point();
        test_zero_cases();
        test_abort();
        test_start_in_fire();
        test_rst_mid_fire();
        test_random();
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
